// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if -- bundle of every handshake/bus signal around the
// instruction/data memory arbiter.
//
// Signal groups:
//   fetch  : IReq_F, IAddr_F, Flush_F  -> arbiter ; IRdata_F, IValid_F <- arbiter
//   data   : DReq_M, DWe_M, DAddr_M, DWdata_M -> arbiter ; DRdata_M, DValid_M <- arbiter
//   memory : Mem_Req, Mem_We, Mem_Addr, Mem_Wdata <- arbiter ;
//            Mem_Ready, Mem_Rvalid, Mem_Rdata -> arbiter
//   stalls : Stall_F, Stall_M <- arbiter
//
// Modports:
//   slave  : the arbiter itself.
//   master : everything around it (pipeline requesters and the memory).
//
// Handshake: a requester raises its Req with address/data stable and keeps
// them stable until its Valid pulses for one cycle. The memory takes the
// request in a cycle where Mem_Req and Mem_Ready are both high, and answers
// later with a one-cycle Mem_Rvalid (read data, or write ack for a store).
interface mem_arbiter_if;
  logic        IReq_F;
  logic [63:0] IAddr_F;
  logic        Flush_F;
  logic [31:0] IRdata_F;
  logic        IValid_F;

  logic        DReq_M;
  logic        DWe_M;
  logic [63:0] DAddr_M;
  logic [63:0] DWdata_M;
  logic [63:0] DRdata_M;
  logic        DValid_M;

  logic        Mem_Req;
  logic        Mem_We;
  logic [63:0] Mem_Addr;
  logic [63:0] Mem_Wdata;
  logic        Mem_Ready;
  logic        Mem_Rvalid;
  logic [63:0] Mem_Rdata;

  logic        Stall_F;
  logic        Stall_M;

  modport slave (
    input  IReq_F, IAddr_F, Flush_F,
    input  DReq_M, DWe_M, DAddr_M, DWdata_M,
    input  Mem_Ready, Mem_Rvalid, Mem_Rdata,
    output IRdata_F, IValid_F, DRdata_M, DValid_M,
    output Mem_Req, Mem_We, Mem_Addr, Mem_Wdata,
    output Stall_F, Stall_M
  );

  modport master (
    output IReq_F, IAddr_F, Flush_F,
    output DReq_M, DWe_M, DAddr_M, DWdata_M,
    output Mem_Ready, Mem_Rvalid, Mem_Rdata,
    input  IRdata_F, IValid_F, DRdata_M, DValid_M,
    input  Mem_Req, Mem_We, Mem_Addr, Mem_Wdata,
    input  Stall_F, Stall_M
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter -- shares one single-port memory between the fetch stage and
// the memory stage. Data requests win by default; after STARVE_LIMIT
// consecutive data grants with a fetch waiting, the fetch wins once.
//
// Ports:
//   clk         : clock, rising edge
//   rst         : asynchronous active-low reset
//   bus         : mem_arbiter_if.slave (fetch, data, memory, stall signals)
//   dbg_state_o : current FSM state (0 IDLE, 1 ISSUE, 2 WAIT)
//   dbg_owner_o : current owner (0 DATA, 1 INSTR)
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_arbiter_if.slave        bus,
  output logic [1:0]          dbg_state_o,
  output logic                dbg_owner_o
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_DATA  = 1'b0,
    OWN_INSTR = 1'b1
  } owner_t;

  state_t        state_q, state_d;
  owner_t        owner_q, owner_d;
  logic [63:0]   addr_q, addr_d;
  logic          we_q, we_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          discard_q, discard_d;
  logic [31:0]   irdata_q, irdata_d;
  logic          ivalid_q, ivalid_d;
  logic [63:0]   drdata_q, drdata_d;
  logic          dvalid_q, dvalid_d;

  logic i_ok;
  logic d_ok;
  logic in_valid_cycle;

  // A flushed fetch is never granted; a completing transaction's valid
  // cycle grants nothing so the requester can present its next request.
  assign i_ok           = bus.IReq_F & ~bus.Flush_F;
  assign d_ok           = bus.DReq_M;
  assign in_valid_cycle = ivalid_q | dvalid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      owner_q   <= OWN_DATA;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      starve_q  <= '0;
      discard_q <= 1'b0;
      irdata_q  <= '0;
      ivalid_q  <= 1'b0;
      drdata_q  <= '0;
      dvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      starve_q  <= starve_d;
      discard_q <= discard_d;
      irdata_q  <= irdata_d;
      ivalid_q  <= ivalid_d;
      drdata_q  <= drdata_d;
      dvalid_q  <= dvalid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    starve_d  = starve_q;
    discard_d = discard_q;
    irdata_d  = irdata_q;
    ivalid_d  = 1'b0;
    drdata_d  = drdata_q;
    dvalid_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        discard_d = 1'b0;
        if (!in_valid_cycle) begin
          if (i_ok && (!d_ok || starve_q == LIMIT)) begin
            owner_d  = OWN_INSTR;
            addr_d   = bus.IAddr_F;
            we_d     = 1'b0;
            wdata_d  = '0;
            starve_d = '0;
            state_d  = S_ISSUE;
          end else if (d_ok) begin
            owner_d = OWN_DATA;
            addr_d  = bus.DAddr_M;
            we_d    = bus.DWe_M;
            wdata_d = bus.DWdata_M;
            // Count only grants that made a fetch wait; saturate at the limit.
            if (bus.IReq_F) begin
              starve_d = (starve_q == LIMIT) ? starve_q : starve_q + 1'b1;
            end else begin
              starve_d = '0;
            end
            state_d = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        if (owner_q == OWN_INSTR && bus.Flush_F) discard_d = 1'b1;
        if (bus.Mem_Ready) state_d = S_WAIT;
      end

      S_WAIT: begin
        if (owner_q == OWN_INSTR && bus.Flush_F) discard_d = 1'b1;
        if (bus.Mem_Rvalid) begin
          state_d   = S_IDLE;
          discard_d = 1'b0;
          if (owner_q == OWN_INSTR) begin
            // A flush in this very cycle also kills the response.
            if (!(discard_q || bus.Flush_F)) begin
              irdata_d = addr_q[2] ? bus.Mem_Rdata[63:32] : bus.Mem_Rdata[31:0];
              ivalid_d = 1'b1;
            end
          end else begin
            drdata_d = we_q ? 64'd0 : bus.Mem_Rdata;
            dvalid_d = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.Mem_Req   = (state_q == S_ISSUE);
  assign bus.Mem_We    = (state_q == S_ISSUE) & we_q;
  assign bus.Mem_Addr  = addr_q;
  assign bus.Mem_Wdata = wdata_q;

  assign bus.IRdata_F  = irdata_q;
  assign bus.IValid_F  = ivalid_q;
  assign bus.DRdata_M  = drdata_q;
  assign bus.DValid_M  = dvalid_q;

  assign bus.Stall_F   = bus.IReq_F & ~ivalid_q & ~bus.Flush_F;
  assign bus.Stall_M   = bus.DReq_M & ~dvalid_q;

  assign dbg_state_o   = state_q;
  assign dbg_owner_o   = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- directed bench for mem_arbiter (STARVE_LIMIT = 4).
// Inputs change and outputs are sampled just after the falling edge.
module tb_mem_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  logic       dbg_owner;

  int err_cnt = 0;
  int chk_cnt = 0;

  logic [0:0] exp_q[$];

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state),
    .dbg_owner_o (dbg_owner)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.IReq_F     = 1'b0;
    bus.IAddr_F    = '0;
    bus.Flush_F    = 1'b0;
    bus.DReq_M     = 1'b0;
    bus.DWe_M      = 1'b0;
    bus.DAddr_M    = '0;
    bus.DWdata_M   = '0;
    bus.Mem_Ready  = 1'b0;
    bus.Mem_Rvalid = 1'b0;
    bus.Mem_Rdata  = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    cyc(2);
    rst = 1'b1;
    cyc(1);
  endtask

  initial begin
    int mreq_cnt;
    int dv_cnt;
    int iv_cnt;
    logic [31:0] last_ir;

    rst = 1'b1;
    do_reset();

    // Reset values
    check("rst_state",    dbg_state, 0);
    check("rst_owner",    dbg_owner, 0);
    check("rst_mem_req",  bus.Mem_Req, 0);
    check("rst_mem_we",   bus.Mem_We, 0);
    check("rst_mem_addr", bus.Mem_Addr, 0);
    check("rst_ivalid",   bus.IValid_F, 0);
    check("rst_dvalid",   bus.DValid_M, 0);
    check("rst_irdata",   bus.IRdata_F, 0);
    check("rst_drdata",   bus.DRdata_M, 0);

    // Lone fetch, upper word, immediate memory
    bus.IReq_F     = 1'b1;
    bus.IAddr_F    = 64'h1004;
    bus.Mem_Ready  = 1'b1;
    bus.Mem_Rvalid = 1'b1;
    bus.Mem_Rdata  = 64'hAABBCCDD_11223344;
    #1;
    check("f_stall_c0",   bus.Stall_F, 1);
    check("f_memreq_c0",  bus.Mem_Req, 0);
    cyc(1);
    check("f_memreq_c1",  bus.Mem_Req, 1);
    check("f_addr_c1",    bus.Mem_Addr, 64'h1004);
    check("f_we_c1",      bus.Mem_We, 0);
    cyc(1);
    check("f_memreq_c2",  bus.Mem_Req, 0);
    check("f_state_c2",   dbg_state, 2);
    check("f_ivalid_c2",  bus.IValid_F, 0);
    cyc(1);
    check("f_ivalid_c3",  bus.IValid_F, 1);
    check("f_irdata_c3",  bus.IRdata_F, 32'hAABBCCDD);
    check("f_stall_c3",   bus.Stall_F, 0);
    bus.IReq_F = 1'b0;
    cyc(1);
    check("f_ivalid_c4",  bus.IValid_F, 0);
    check("f_state_c4",   dbg_state, 0);
    bus.Mem_Rvalid = 1'b0;

    // Store with Mem_Ready delayed 3 cycles
    bus.DReq_M    = 1'b1;
    bus.DWe_M     = 1'b1;
    bus.DAddr_M   = 64'h2000;
    bus.DWdata_M  = 64'h55;
    bus.Mem_Ready = 1'b0;
    #1;
    check("s_stall_c0", bus.Stall_M, 1);
    mreq_cnt = 0;
    for (int i = 1; i <= 4; i++) begin
      cyc(1);
      if (i == 4) bus.Mem_Ready = 1'b1;
      #1;
      if (bus.Mem_Req === 1'b1) mreq_cnt++;
      check("s_we_issue",    bus.Mem_We, 1);
      check("s_addr_issue",  bus.Mem_Addr, 64'h2000);
      check("s_wdata_issue", bus.Mem_Wdata, 64'h55);
      check("s_stall_issue", bus.Stall_M, 1);
    end
    check("s_memreq_cycles", mreq_cnt, 4);
    cyc(1);
    check("s_memreq_wait", bus.Mem_Req, 0);
    check("s_stall_wait",  bus.Stall_M, 1);
    bus.Mem_Rvalid = 1'b1;
    bus.Mem_Rdata  = 64'hDEAD_BEEF;
    dv_cnt = 0;
    cyc(1);
    check("s_drdata", bus.DRdata_M, 0);
    check("s_stall_done", bus.Stall_M, 0);
    if (bus.DValid_M === 1'b1) dv_cnt++;
    bus.DReq_M     = 1'b0;
    bus.Mem_Rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      if (bus.DValid_M === 1'b1) dv_cnt++;
    end
    check("s_dvalid_pulses", dv_cnt, 1);

    // Starvation: both requesting continuously
    do_reset();
    exp_q = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    bus.IReq_F     = 1'b1;
    bus.IAddr_F    = 64'h3000;
    bus.DReq_M     = 1'b1;
    bus.DWe_M      = 1'b0;
    bus.DAddr_M    = 64'h100;
    bus.Mem_Ready  = 1'b1;
    bus.Mem_Rvalid = 1'b1;
    bus.Mem_Rdata  = 64'h12345678_9ABCDEF0;
    iv_cnt  = 0;
    last_ir = '0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (bus.Mem_Req === 1'b1) begin
        if (exp_q.size() == 0) check("a_extra_grant", 1, 0);
        else check("a_grant_owner", dbg_owner, exp_q.pop_front());
      end
      if (bus.IValid_F === 1'b1) begin
        iv_cnt++;
        last_ir = bus.IRdata_F;
      end
      cyc(1);
    end
    check("a_grants_left", exp_q.size(), 0);
    check("a_ivalid_seen", (iv_cnt != 0), 1);
    check("a_irdata_lo",   last_ir, 32'h9ABCDEF0);
    check("a_drdata_load", bus.DRdata_M, 64'h12345678_9ABCDEF0);

    // Flush during WAIT of a fetch
    do_reset();
    bus.IReq_F    = 1'b1;
    bus.IAddr_F   = 64'h40;
    bus.Mem_Ready = 1'b1;
    cyc(2);
    check("fl_state_wait", dbg_state, 2);
    bus.Flush_F = 1'b1;
    #1;
    check("fl_stall_flush", bus.Stall_F, 0);
    cyc(1);
    bus.Flush_F    = 1'b0;
    bus.IReq_F     = 1'b0;
    bus.Mem_Rvalid = 1'b1;
    bus.Mem_Rdata  = 64'h1111_2222_3333_4444;
    check("fl_still_wait", dbg_state, 2);
    cyc(1);
    bus.Mem_Rvalid = 1'b0;
    check("fl_ivalid_0", bus.IValid_F, 0);
    check("fl_state_idle", dbg_state, 0);
    cyc(1);
    check("fl_ivalid_1", bus.IValid_F, 0);

    // Flush in IDLE blocks the fetch grant but not a data grant
    bus.IReq_F  = 1'b1;
    bus.Flush_F = 1'b1;
    cyc(1);
    check("fi_no_grant", dbg_state, 0);
    bus.IReq_F  = 1'b0;
    bus.DReq_M  = 1'b1;
    bus.DAddr_M = 64'h500;
    cyc(1);
    check("fi_data_grant", bus.Mem_Req, 1);
    check("fi_data_owner", dbg_owner, 0);

    // Reset in WAIT, late Mem_Rvalid ignored
    do_reset();
    bus.DReq_M    = 1'b1;
    bus.DWe_M     = 1'b0;
    bus.DAddr_M   = 64'h88;
    bus.Mem_Ready = 1'b1;
    cyc(2);
    check("r_state_wait", dbg_state, 2);
    rst = 1'b0;
    bus.DReq_M = 1'b0;
    #1;
    check("r_async_state", dbg_state, 0);
    check("r_async_addr",  bus.Mem_Addr, 0);
    cyc(2);
    rst = 1'b1;
    bus.Mem_Rvalid = 1'b1;
    bus.Mem_Rdata  = 64'hCAFE;
    dv_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      if (bus.DValid_M === 1'b1 || bus.IValid_F === 1'b1) dv_cnt++;
    end
    check("r_no_valid",  dv_cnt, 0);
    check("r_state_idle", dbg_state, 0);
    check("r_drdata",    bus.DRdata_M, 0);
    check("r_mem_req",   bus.Mem_Req, 0);
    bus.Mem_Rvalid = 1'b0;

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
